// File: rtl/mod12_seq_ctrl_if.sv
// Command channel for the mod-12 counter sequencer.
// A command transfers on a rising edge where cmd_valid && cmd_ready; the source holds op/arg stable until then.
interface mod12_seq_ctrl_if #(
    parameter int CW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/mod12_seq_ctrl.sv
// Sequencer driving a mod-12 up/down counter through its load/updown/d_in pins.
// Executes LOAD, STEP_UP, STEP_DOWN and SEEK (shortest path, ties go up).
module mod12_seq_ctrl #(
    parameter int MOD = 12,
    parameter int CW  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mod12_seq_ctrl_if.slave cmd,
    input  logic            i_abort,
    input  logic [CW-1:0]   i_cnt_q,
    output logic            o_cnt_load,
    output logic            o_cnt_updown,
    output logic [CW-1:0]   o_cnt_d_in,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [1:0]      o_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SEEK = 2'b11;

    localparam logic [CW-1:0] MAX_POS = CW'(MOD - 1);
    localparam logic [CW-1:0] MOD_V   = CW'(MOD);

    logic [1:0]    r_state;
    logic          r_dir;
    logic [CW-1:0] r_remaining;
    logic [CW-1:0] r_ld_val;
    logic          r_done;
    logic          r_err;

    logic          w_accept;
    logic          w_arg_bad;
    logic [CW-1:0] w_du;
    logic [CW-1:0] w_dd;

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign w_accept      = cmd.cmd_valid && (r_state == S_IDLE);
    assign w_arg_bad     = (cmd.cmd_arg > MAX_POS);

    // Up/down distance to the seek target; wraps in CW bits when arg < cnt_q.
    assign w_du = (cmd.cmd_arg >= i_cnt_q) ? (cmd.cmd_arg - i_cnt_q)
                                           : (cmd.cmd_arg - i_cnt_q + MOD_V);
    assign w_dd = (w_du == '0) ? '0 : (MOD_V - w_du);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_remaining <= '0;
            r_ld_val    <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (cmd.cmd_op == OP_LOAD) begin
                            if (w_arg_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_ld_val <= cmd.cmd_arg;
                                r_state  <= S_LOAD;
                            end
                        end else if (cmd.cmd_op == OP_SEEK) begin
                            if (w_arg_bad) begin
                                r_err <= 1'b1;
                            end else if (w_du == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_dir       <= (w_du > w_dd);
                                r_remaining <= (w_du <= w_dd) ? w_du : w_dd;
                                r_state     <= S_RUN;
                            end
                        end else begin
                            if (cmd.cmd_arg == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_dir       <= cmd.cmd_op[1];
                                r_remaining <= cmd.cmd_arg;
                                r_state     <= S_RUN;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                S_RUN: begin
                    if (i_abort || (r_remaining == CW'(1))) begin
                        r_state     <= S_IDLE;
                        r_remaining <= '0;
                        r_done      <= 1'b1;
                    end else begin
                        r_remaining <= r_remaining - CW'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_remaining <= '0;
                end
            endcase
        end
    end

    // The counter has no enable: anything other than an active step or load reloads cnt_q.
    always_comb begin
        o_cnt_load   = 1'b1;
        o_cnt_updown = 1'b0;
        o_cnt_d_in   = i_cnt_q;
        if (!i_rst_n) begin
            o_cnt_d_in = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (!i_abort) o_cnt_d_in = r_ld_val;
                end
                S_RUN: begin
                    if (!i_abort) begin
                        o_cnt_load   = 1'b0;
                        o_cnt_updown = r_dir;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (r_state == S_LOAD) || (r_state == S_RUN);
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_state = r_state;
endmodule

// File: tb/tb_mod12_seq_ctrl.sv
// Directed bench for mod12_seq_ctrl with a behavioural mod-12 counter closing the loop.
module tb_mod12_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic [3:0] cnt = 4'd0;
    logic       cnt_load;
    logic       cnt_updown;
    logic [3:0] cnt_d_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    mod12_seq_ctrl_if #(.CW(4)) cmd_if ();

    mod12_seq_ctrl #(.MOD(12), .CW(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .cmd          (cmd_if),
        .i_abort      (abort),
        .i_cnt_q      (cnt),
        .o_cnt_load   (cnt_load),
        .o_cnt_updown (cnt_updown),
        .o_cnt_d_in   (cnt_d_in),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    // Mod-12 counter: load wins, otherwise step up (0) or down (1) with wrap.
    always_ff @(posedge clk) begin
        if (cnt_load)        cnt <= cnt_d_in;
        else if (cnt_updown) cnt <= (cnt == 4'd0)  ? 4'd11 : cnt - 4'd1;
        else                 cnt <= (cnt == 4'd11) ? 4'd0  : cnt + 4'd1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] arg);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {7'd0, done}, 8'd1);
    endtask

    task automatic load_val(input logic [3:0] v);
        send_cmd(2'b00, v);
        wait_done("load_helper_done");
    endtask

    task automatic check_steps(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, {4'd0, cnt}, {4'd0, exp_q.pop_front()});
            if (i == n - 1) check({tag, "_done"}, {7'd0, done}, 8'd1);
            else            check({tag, "_busy"}, {7'd0, busy}, 8'd1);
        end
    endtask

    initial begin
        int pulses;
        rst_n            = 1'b0;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_arg   = 4'd0;

        #12;
        check("rst_load",   {7'd0, cnt_load},        8'd1);
        check("rst_d_in",   {4'd0, cnt_d_in},        8'd0);
        check("rst_updown", {7'd0, cnt_updown},      8'd0);
        check("rst_ready",  {7'd0, cmd_if.cmd_ready}, 8'd1);
        check("rst_done",   {6'd0, done, err},       8'd0);
        check("rst_state",  {6'd0, state},           8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // LOAD 7
        send_cmd(2'b00, 4'd7);
        check("ld_state", {6'd0, state},    8'd1);
        check("ld_load",  {7'd0, cnt_load}, 8'd1);
        check("ld_d_in",  {4'd0, cnt_d_in}, 8'd7);
        check("ld_busy",  {7'd0, busy},     8'd1);
        check("ld_ready", {7'd0, cmd_if.cmd_ready}, 8'd0);
        @(negedge clk);
        check("ld_done",  {7'd0, done}, 8'd1);
        check("ld_err",   {7'd0, err},  8'd0);
        check("ld_cnt",   {4'd0, cnt},  8'd7);
        check("ld_ready2", {7'd0, cmd_if.cmd_ready}, 8'd1);
        @(negedge clk);
        check("ld_done_pulse", {7'd0, done}, 8'd0);

        // STEP_UP 5 from 9 wraps through 0
        load_val(4'd9);
        send_cmd(2'b01, 4'd5);
        check("up5_load", {7'd0, cnt_load},   8'd0);
        check("up5_dir",  {7'd0, cnt_updown}, 8'd0);
        exp_q = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd2};
        check_steps("up5");
        @(negedge clk);
        check("up5_hold",  {4'd0, cnt},  8'd2);
        check("up5_pulse", {7'd0, done}, 8'd0);
        check("up5_hold_d", {4'd0, cnt_d_in}, 8'd2);

        // SEEK 10 from 1 goes down 3
        load_val(4'd1);
        send_cmd(2'b11, 4'd10);
        check("seek10_dir", {7'd0, cnt_updown}, 8'd1);
        exp_q = '{4'd0, 4'd11, 4'd10};
        check_steps("seek10");

        // SEEK 6 from 0 is a tie and goes up
        load_val(4'd0);
        send_cmd(2'b11, 4'd6);
        check("seek6_dir", {7'd0, cnt_updown}, 8'd0);
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        check_steps("seek6");

        // SEEK 0 from 0 completes immediately
        load_val(4'd0);
        send_cmd(2'b11, 4'd0);
        check("seek0_done", {7'd0, done}, 8'd1);
        check("seek0_busy", {7'd0, busy}, 8'd0);
        check("seek0_cnt",  {4'd0, cnt},  8'd0);

        // STEP of 0 completes immediately
        send_cmd(2'b10, 4'd0);
        check("step0_done", {7'd0, done}, 8'd1);
        check("step0_busy", {7'd0, busy}, 8'd0);

        // STEP_UP 15 from 3 wraps and ends at 6
        load_val(4'd3);
        send_cmd(2'b01, 4'd15);
        exp_q.delete();
        for (int i = 4; i < 12; i++) exp_q.push_back(4'(i));
        for (int i = 0; i < 7; i++)  exp_q.push_back(4'(i));
        check_steps("up15");

        // Illegal LOAD and SEEK arguments
        send_cmd(2'b00, 4'd13);
        check("ld13_err",   {7'd0, err},   8'd1);
        check("ld13_done",  {7'd0, done},  8'd0);
        check("ld13_state", {6'd0, state}, 8'd0);
        check("ld13_cnt",   {4'd0, cnt},   8'd6);
        @(negedge clk);
        check("ld13_pulse", {6'd0, done, err}, 8'd0);
        check("ld13_cnt2",  {4'd0, cnt},   8'd6);
        send_cmd(2'b11, 4'd12);
        check("seek12_err",  {7'd0, err},  8'd1);
        check("seek12_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        check("seek12_pulse", {6'd0, done, err}, 8'd0);
        check("seek12_cnt",   {4'd0, cnt},       8'd6);

        // abort in IDLE does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_done", {7'd0, done}, 8'd0);
        check("abort_idle_cnt",  {4'd0, cnt},  8'd6);

        // STEP_DOWN 10 from 4, abort on the third RUN cycle
        load_val(4'd4);
        send_cmd(2'b10, 4'd10);
        check("abort_c1", {4'd0, cnt}, 8'd4);
        @(negedge clk);
        check("abort_c2", {4'd0, cnt}, 8'd3);
        @(negedge clk);
        check("abort_c3", {4'd0, cnt}, 8'd2);
        abort = 1'b1;
        #1;
        check("abort_load", {7'd0, cnt_load}, 8'd1);
        check("abort_d_in", {4'd0, cnt_d_in}, 8'd2);
        @(negedge clk);
        check("abort_done",  {7'd0, done}, 8'd1);
        check("abort_cnt",   {4'd0, cnt},  8'd2);
        check("abort_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
        abort = 1'b0;
        @(negedge clk);
        check("abort_pulse", {7'd0, done}, 8'd0);
        check("abort_hold",  {4'd0, cnt},  8'd2);

        // Reset in the middle of a RUN
        load_val(4'd5);
        send_cmd(2'b01, 4'd5);
        @(negedge clk);
        check("mid_busy", {7'd0, busy}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_load",   {7'd0, cnt_load},   8'd1);
        check("mid_rst_d_in",   {4'd0, cnt_d_in},   8'd0);
        check("mid_rst_updown", {7'd0, cnt_updown}, 8'd0);
        check("mid_rst_state",  {6'd0, state},      8'd0);
        pulses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("mid_rst_no_done", 8'(pulses), 8'd0);
        check("mid_rst_cnt",     {4'd0, cnt}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mod12_seq_ctrl.md
Name: mod12_seq_ctrl

Overview:
- Command-driven sequencer for the mod-12 up/down counter.
- Accepts LOAD, STEP-UP, STEP-DOWN and SEEK commands over a valid/ready handshake and drives the counter's load/updown/d_in pins.
- Reads the counter's d_out back as cnt_q.
- The counter has no enable, so the controller holds its value by reloading cnt_q whenever no stepping is requested.

Parameters:
- MOD, 12, counter modulus; legal positions 0..MOD-1 (fixed at 12 for this counter).
- CW, 4, width of position, count and command argument.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 LOAD, 01 STEP_UP, 10 STEP_DOWN, 11 SEEK.
- cmd_arg  in  4  LOAD value, STEP count (0..15) or SEEK target.
- abort  in  1  stop the current LOAD/RUN at the next edge.
- cnt_q  in  4  counter d_out.
- cnt_load  out  1  to counter load.
- cnt_updown  out  1  to counter updown (0 = up, 1 = down).
- cnt_d_in  out  4  to counter d_in.
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: illegal argument, command rejected.

Behaviour:
- States: IDLE, LOAD, RUN. Registers: state, dir, remaining[3:0], ld_val[3:0], done, err.
- Reset (rst low, asynchronous):
  - state = IDLE; remaining = 0; dir = 0; done = 0; err = 0.
  - Outputs while rst is low: cnt_load = 1, cnt_d_in = 0, cnt_updown = 0.
- Output decode (combinational from state):
  - IDLE: cnt_load = 1, cnt_d_in = cnt_q (hold).
  - LOAD: cnt_load = 1, cnt_d_in = ld_val.
  - RUN: cnt_load = 0, cnt_updown = dir.
  - cnt_updown = 0 outside RUN.
- Handshake:
  - cmd_ready = (state == IDLE).
  - Accept when cmd_valid && cmd_ready on cycle T; the command is sampled at the T edge.
  - cmd_valid is ignored while busy; the source holds it until ready.
- Acceptance per op (cur = cnt_q at T):
  - LOAD:
    - arg > 11: err = 1 at T+1, state stays IDLE, nothing applied.
    - Otherwise: ld_val = arg, state LOAD during T+1, counter takes the value at the T+1 edge; IDLE and done = 1 at T+2.
  - STEP_UP / STEP_DOWN:
    - count 0: done = 1 at T+1, state stays IDLE.
    - count N > 0: dir = op[1], remaining = N, RUN from T+1. Each RUN cycle the counter steps once and remaining decrements.
    - On the edge where remaining == 1, go to IDLE and set done. done is visible at T+N+1 with the counter holding its final value.
    - Wrap is handled by the counter (11 -> 0 up, 0 -> 11 down). N > 12 wraps more than once; e.g. 15 up from 3 ends at 6.
  - SEEK:
    - arg > 11: err pulse, as for LOAD.
    - du = (arg - cur + 12) mod 12; dd = (12 - du) mod 12.
    - du == 0: done at T+1, no motion.
    - du <= dd (a tie picks up): dir = 0, remaining = du.
    - Otherwise: dir = 1, remaining = dd.
    - Then as STEP; at most 6 steps.
- done and err are registered pulses, high exactly one cycle.
  - A new command may be accepted in the same cycle done is high (state is IDLE).
  - done and err are never high together.
- abort:
  - Sampled only in LOAD or RUN.
  - At that edge: state goes to IDLE, remaining is cleared, done = 1.
  - No step or load occurs at that edge; the controller drives load=1 and holds cnt_q as the counter value.
  - abort in IDLE has no effect.
  - When abort coincides with the final step, the abort wins and that final step does not happen.
- cnt_q values above 11 are not produced by this controller. If seen in SEEK, they are treated modulo 16 in the subtraction and the result is unspecified.
- Reset mid-RUN: the controller returns to IDLE immediately, and no done pulse follows.

Test Plan:
- Reset, then LOAD 7 -> cnt_load = 1 with cnt_d_in = 7 in the LOAD cycle; cnt_q = 7; done pulses at T+2; err = 0.
- cnt_q = 9, STEP_UP 5 -> five up steps 10, 11, 0, 1, 2; done at T+6; cnt_q stays 2 afterwards (hold).
- cnt_q = 1, SEEK 10 -> du = 9, dd = 3, so down; sequence 0, 11, 10; done at T+4.
- cnt_q = 0, SEEK 6 -> tie, so up 6 steps ending at 6. SEEK 0 from 0 -> done at T+1, no motion.
- LOAD 13 and SEEK 12 -> err pulse one cycle, cnt_q unchanged, no done.
- STEP_DOWN 10 from 4, abort on the 3rd RUN cycle -> cnt_q = 2, done pulses, cmd_ready high.
- Separately, rst low mid-RUN -> cnt_load = 1, cnt_d_in = 0 immediately; no done.
